csr_trap_unit: RTL and testbench
================================

# csr_trap_unit

Machine-mode CSR file and trap sequencer for the RV32I-Trap core. It sits directly downstream of the instruction controller and consumes its decoded CSR controls, IllegalInstruction and MRET flags once they reach execute. It holds the machine CSRs, performs CSR read/write/set/clear, and takes illegal-instruction exceptions and machine external/timer interrupts. It handles MRET and issues a one-cycle PC redirect/flush to fetch.

## Interface
- RESET_MTVEC, 32'h0000_0100, reset value of mtvec.
- clk  in  1  core clock; all state on rising edge.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- valid_i  in  1  execute-stage instruction is valid (not a bubble).
- pc_i  in  32  PC of the execute-stage instruction.
- instr_i  in  32  instruction word, captured into mtval on an illegal instruction.
- csr_write_i / csr_set_i / csr_clear_i  in  1 each  CSR operation type from the controller; at most one is high.
- csr_addr_i  in  12  CSR address (instr[31:20]).
- csr_wdata_i  in  32  operand, either rs1 or zero-extended zimm, already muxed.
- illegal_i  in  1  IllegalInstruction from the controller.
- mret_i  in  1  MRET from the controller.
- irq_ext_i, irq_timer_i  in  1 each  level-sensitive interrupt lines.
- csr_rdata_o  out  32  old value of the addressed CSR (combinational), written to rd.
- redirect_o  out  1  one-cycle PC redirect plus flush of IF/ID/EX.
- redirect_pc_o  out  32  redirect target, valid while redirect_o is high.

## Operation
- CSRs and their addresses:
  - mstatus 0x300: MIE bit 3, MPIE bit 7; MPP[12:11] reads 2'b11 and is not writable; all other bits read 0.
  - mie 0x304: MEIE bit 11, MTIE bit 7.
  - mtvec 0x305: direct mode only; bits [1:0] forced to 0.
  - mscratch 0x340.
  - mepc 0x341: bits [1:0] forced to 0.
  - mcause 0x342, mtval 0x343.
  - mip 0x344: read-only; MEIP = irq_ext_i, MTIP = irq_timer_i.
  - mcycle 0xB00, mcycleh 0xB80.
- CSR update rules:
  - write: new = wdata.
  - set: new = old | wdata.
  - clear: new = old & ~wdata.
  - A set or clear with wdata = 0 leaves the CSR unchanged.
  - Writes to mip are ignored.
- Any CSR op to an unlisted address is treated as illegal (cause 2).
- mcycle/mcycleh form a 64-bit counter that increments every cycle and wraps 2^64-1 -> 0. A CSR write to either half replaces that half that cycle; the increment is skipped for that cycle.
- Event priority, evaluated only when valid_i=1 and state=RUN:
  1. External interrupt: MIE & MEIE & irq_ext_i -> mcause 0x8000000B.
  2. Timer interrupt: MIE & MTIE & irq_timer_i -> mcause 0x80000007.
  3. Illegal: illegal_i or bad CSR address -> mcause 0x00000002, mtval = instr_i.
  4. mret_i.
  5. Otherwise, perform the CSR op.
- Trap entry, for events 1-3:
  - mepc <= pc_i; mcause <= code; mtval <= instr_i for illegal, 0 for interrupts.
  - MPIE <= MIE; MIE <= 0.
  - The CSR op of the trapping instruction is suppressed.
  - Target is mtvec.
- MRET: MIE <= MPIE; MPIE <= 1; target is mepc.
- State machine:
  - RUN: a trap or MRET goes to REDIRECT; otherwise stay in RUN.
  - REDIRECT: always returns to RUN.
  - In REDIRECT, all inputs are ignored and only mcycle changes.

## Timing
- CSR read is combinational: csr_rdata_o reflects the pre-update value in the same cycle as csr_addr_i.
- CSR writes and trap-entry updates take effect at the clock edge ending cycle N, the cycle of the event.
- redirect_o=1 with redirect_pc_o during cycle N+1 only, one cycle exactly.
- redirect_pc_o is registered: the mtvec/mepc value sampled in cycle N. A CSR write to mtvec/mepc in cycle N is not visible as the target until a later trap.
- Back-to-back: an event in the cycle after REDIRECT is taken normally, so the minimum trap spacing is 2 cycles.
- Reset, asynchronous, values:
  - All CSRs 0, except mtvec = RESET_MTVEC; MPP reads 11.
  - State RUN; redirect_o=0; redirect_pc_o=0; mcycle=0.
- Reset asserted mid-REDIRECT clears redirect_o immediately.
- An interrupt line deasserting while a redirect is already in flight has no effect on that redirect.

## Structure
- Package rv_csr_pkg holds:
  - CSR address localparams.
  - mcause codes.
  - mstatus/mie bit indices.
  - State encoding (RUN=0, REDIRECT=1).
- Sub-module cycle_counter: 64-bit counter with per-half load enables.

## Test plan
- CSRRW 0x340 with wdata 0xDEADBEEF, then CSRRS 0x340 with wdata 0x1 -> second read returns 0xDEADBEEF; mscratch = 0xDEADBEEF.
- illegal_i with pc 0x40, instr 0xFFFFFFFF, mtvec 0x100 -> next cycle redirect_o=1, pc 0x100; mepc=0x40, mcause=2, mtval=0xFFFFFFFF; MIE 1->0 with MPIE=1.
- MIE=1, MTIE=1, irq_timer_i and a CSRRW to mscratch in the same cycle -> mcause 0x80000007; mscratch unchanged; mepc = that PC.
- MRET with mepc 0x44, MPIE=1 -> redirect to 0x44; MIE=1, MPIE=1; no second redirect on the following cycle.
- CSRRW 0xB00 with 0xFFFFFFFF and mcycleh 0 -> 2 cycles later mcycleh=1, mcycle=0x00000000.
- CSRRS to 0x7C0 -> illegal trap, mcause=2; rst_n pulsed during REDIRECT -> redirect_o drops immediately, mtvec=0x100.

Source files
------------

// File: rtl/csr_trap_unit_pkg.sv
// Shared definitions for the machine-mode CSR file and trap sequencer:
// CSR addresses, trap cause codes, mstatus/mie bit positions and masks,
// sequencer state encoding and small CSR helper functions.
package rv_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;

    localparam logic [31:0] CAUSE_EXT_IRQ   = 32'h8000_000B;
    localparam logic [31:0] CAUSE_TIMER_IRQ = 32'h8000_0007;
    localparam logic [31:0] CAUSE_ILLEGAL   = 32'h0000_0002;

    localparam int unsigned MSTATUS_MIE_BIT  = 32'd3;
    localparam int unsigned MSTATUS_MPIE_BIT = 32'd7;
    localparam int unsigned MIE_MTIE_BIT     = 32'd7;
    localparam int unsigned MIE_MEIE_BIT     = 32'd11;

    localparam logic [31:0] MSTATUS_MIE_MASK  = 32'h0000_0008;
    localparam logic [31:0] MSTATUS_MPIE_MASK = 32'h0000_0080;
    localparam logic [31:0] MSTATUS_WMASK     = 32'h0000_0088;
    localparam logic [31:0] MSTATUS_MPP_BITS  = 32'h0000_1800;
    localparam logic [31:0] MIE_WMASK         = 32'h0000_0880;
    localparam logic [31:0] ALIGN4_MASK       = 32'hFFFF_FFFC;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_REDIRECT = 1'b1
    } trap_state_e;

    // True for every CSR address implemented by this unit.
    function automatic logic csr_known(input logic [11:0] addr);
        logic known;
        case (addr)
            CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
            CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MCYCLEH: known = 1'b1;
            default: known = 1'b0;
        endcase
        return known;
    endfunction

    // Value after a write, set or clear; clear is the remaining case.
    function automatic logic [31:0] csr_apply(input logic op_write, input logic op_set,
                                              input logic [31:0] old_value,
                                              input logic [31:0] operand);
        logic [31:0] result;
        if (op_write) begin
            result = operand;
        end else if (op_set) begin
            result = old_value | operand;
        end else begin
            result = old_value & ~operand;
        end
        return result;
    endfunction

endpackage

// File: rtl/csr_trap_unit_cycle_counter.sv
// Free-running 64-bit cycle counter; either 32-bit half can be loaded,
// and a load replaces the increment for that cycle.
module cycle_counter
    import rv_csr_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_lo,
    input  logic        load_hi,
    input  logic [31:0] load_data,
    output logic [63:0] count
);

    logic [63:0] count_r;

    // Count every cycle unless one half is being loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 64'd0;
        end else if (load_lo) begin
            count_r[31:0] <= load_data;
        end else if (load_hi) begin
            count_r[63:32] <= load_data;
        end else begin
            count_r <= count_r + 64'd1;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer. Arbitrates interrupts, illegal
// instructions, MRET and CSR ops for the execute-stage instruction and
// issues a registered one-cycle redirect to fetch.
module csr_trap_unit
    import rv_csr_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic        csr_write_i,
    input  logic        csr_set_i,
    input  logic        csr_clear_i,
    input  logic [11:0] csr_addr_i,
    input  logic [31:0] csr_wdata_i,
    input  logic        illegal_i,
    input  logic        mret_i,
    input  logic        irq_ext_i,
    input  logic        irq_timer_i,
    output logic [31:0] csr_rdata_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o
);

    logic [31:0] mstatus_r, mie_r, mtvec_r, mscratch_r, mepc_r, mcause_r, mtval_r;
    logic [31:0] mip_s, rdata_s, new_val_s, trap_cause_s;
    logic [63:0] mcycle_s;
    logic        op_any_s, run_s, ext_irq_s, timer_irq_s, illegal_s, trap_s, mret_s, do_op_s;
    logic        mcycle_wr_s;
    trap_state_e state_r, state_next_s;
    logic        redirect_r;
    logic [31:0] redirect_pc_r;

    // Events are only considered for a real instruction outside a redirect;
    // the ordering below encodes the ext > timer > illegal > mret > op priority.
    assign op_any_s    = csr_write_i | csr_set_i | csr_clear_i;
    assign run_s       = valid_i && (state_r == ST_RUN);
    assign ext_irq_s   = run_s && mstatus_r[MSTATUS_MIE_BIT] && mie_r[MIE_MEIE_BIT] && irq_ext_i;
    assign timer_irq_s = run_s && mstatus_r[MSTATUS_MIE_BIT] && mie_r[MIE_MTIE_BIT] && irq_timer_i
                         && !ext_irq_s;
    assign illegal_s   = run_s && (illegal_i || (op_any_s && !csr_known(csr_addr_i)))
                         && !ext_irq_s && !timer_irq_s;
    assign trap_s      = ext_irq_s || timer_irq_s || illegal_s;
    assign mret_s      = run_s && mret_i && !trap_s;
    assign do_op_s     = run_s && op_any_s && !trap_s && !mret_s;

    assign trap_cause_s = ext_irq_s   ? CAUSE_EXT_IRQ :
                          timer_irq_s ? CAUSE_TIMER_IRQ : CAUSE_ILLEGAL;

    assign mip_s     = {20'd0, irq_ext_i, 3'd0, irq_timer_i, 7'd0};
    assign new_val_s = csr_apply(csr_write_i, csr_set_i, rdata_s, csr_wdata_i);

    // A set/clear with a zero operand is not a write, so the counter keeps counting.
    assign mcycle_wr_s = do_op_s && (csr_write_i || (csr_wdata_i != 32'd0));

    cycle_counter u_cycle_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_lo   (mcycle_wr_s && (csr_addr_i == CSR_MCYCLE)),
        .load_hi   (mcycle_wr_s && (csr_addr_i == CSR_MCYCLEH)),
        .load_data (new_val_s),
        .count     (mcycle_s)
    );

    // Combinational read of the addressed CSR (pre-update value).
    always_comb begin
        rdata_s = 32'd0;
        case (csr_addr_i)
            CSR_MSTATUS:  rdata_s = mstatus_r | MSTATUS_MPP_BITS;
            CSR_MIE:      rdata_s = mie_r;
            CSR_MTVEC:    rdata_s = mtvec_r;
            CSR_MSCRATCH: rdata_s = mscratch_r;
            CSR_MEPC:     rdata_s = mepc_r;
            CSR_MCAUSE:   rdata_s = mcause_r;
            CSR_MTVAL:    rdata_s = mtval_r;
            CSR_MIP:      rdata_s = mip_s;
            CSR_MCYCLE:   rdata_s = mcycle_s[31:0];
            CSR_MCYCLEH:  rdata_s = mcycle_s[63:32];
            default:      rdata_s = 32'd0;
        endcase
    end

    assign csr_rdata_o = rdata_s;

    // CSR state: trap entry and MRET take precedence over the instruction's own CSR op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_r  <= 32'd0;
            mie_r      <= 32'd0;
            mtvec_r    <= RESET_MTVEC;
            mscratch_r <= 32'd0;
            mepc_r     <= 32'd0;
            mcause_r   <= 32'd0;
            mtval_r    <= 32'd0;
        end else if (trap_s) begin
            mepc_r    <= pc_i & ALIGN4_MASK;
            mcause_r  <= trap_cause_s;
            mtval_r   <= illegal_s ? instr_i : 32'd0;
            mstatus_r <= mstatus_r[MSTATUS_MIE_BIT] ? MSTATUS_MPIE_MASK : 32'd0;
        end else if (mret_s) begin
            mstatus_r <= MSTATUS_MPIE_MASK |
                         (mstatus_r[MSTATUS_MPIE_BIT] ? MSTATUS_MIE_MASK : 32'd0);
        end else if (do_op_s) begin
            case (csr_addr_i)
                CSR_MSTATUS:  mstatus_r  <= new_val_s & MSTATUS_WMASK;
                CSR_MIE:      mie_r      <= new_val_s & MIE_WMASK;
                CSR_MTVEC:    mtvec_r    <= new_val_s & ALIGN4_MASK;
                CSR_MSCRATCH: mscratch_r <= new_val_s;
                CSR_MEPC:     mepc_r     <= new_val_s & ALIGN4_MASK;
                CSR_MCAUSE:   mcause_r   <= new_val_s;
                CSR_MTVAL:    mtval_r    <= new_val_s;
                default:      begin end
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state: any trap or MRET costs exactly one redirect cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (trap_s || mret_s) begin
                    state_next_s = ST_REDIRECT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_REDIRECT: state_next_s = ST_RUN;
            default:     state_next_s = ST_RUN;
        endcase
    end

    // Redirect target is captured from the pre-update mtvec/mepc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_r    <= 1'b0;
            redirect_pc_r <= 32'd0;
        end else begin
            redirect_r <= trap_s || mret_s;
            if (trap_s) begin
                redirect_pc_r <= mtvec_r;
            end else if (mret_s) begin
                redirect_pc_r <= mepc_r;
            end
        end
    end

    assign redirect_o    = redirect_r;
    assign redirect_pc_o = redirect_pc_r;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Scoreboard bench for csr_trap_unit: a reference model pushes expected
// read data and redirects into queues; a monitor pops and compares.
module tb_csr_trap_unit;
    import rv_csr_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic [31:0] pc_i = 32'd0;
    logic [31:0] instr_i = 32'd0;
    logic        csr_write_i = 1'b0, csr_set_i = 1'b0, csr_clear_i = 1'b0;
    logic [11:0] csr_addr_i = 12'h000;
    logic [31:0] csr_wdata_i = 32'd0;
    logic        illegal_i = 1'b0, mret_i = 1'b0;
    logic        irq_ext_i = 1'b0, irq_timer_i = 1'b0;
    logic [31:0] csr_rdata_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;

    csr_trap_unit #(.RESET_MTVEC(32'h0000_0100)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .pc_i(pc_i), .instr_i(instr_i),
        .csr_write_i(csr_write_i), .csr_set_i(csr_set_i), .csr_clear_i(csr_clear_i),
        .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i), .illegal_i(illegal_i),
        .mret_i(mret_i), .irq_ext_i(irq_ext_i), .irq_timer_i(irq_timer_i),
        .csr_rdata_o(csr_rdata_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    exp_t rd_q[$];
    exp_t rdr_q[$];

    localparam logic [1:0] NO = 2'd0, WR = 2'd1, ST = 2'd2, CL = 2'd3;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    logic ext_nxt = 1'b0, tmr_nxt = 1'b0;

    // Reference model state: CSRs by address, 64-bit cycle count, redirect flag.
    logic [31:0] csr_m [logic [11:0]];
    logic [63:0] mcyc;
    bit          m_redirect;

    logic [11:0] addr_tbl [12] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                   12'h343, 12'h344, 12'hB00, 12'hB80, 12'h7C0, 12'h001};

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic logic [31:0] wmask(input logic [11:0] a);
        case (a)
            12'h300: return 32'h0000_0088;
            12'h304: return 32'h0000_0880;
            12'h305, 12'h341: return 32'hFFFF_FFFC;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic bit known(input logic [11:0] a);
        return (csr_m.exists(a) != 0) || a == 12'h344 || a == 12'hB00 || a == 12'hB80;
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a);
        if (a == 12'h300) return csr_m[a] | 32'h0000_1800;
        else if (a == 12'h344) return {20'd0, irq_ext_i, 3'd0, irq_timer_i, 7'd0};
        else if (a == 12'hB00) return mcyc[31:0];
        else if (a == 12'hB80) return mcyc[63:32];
        else if (csr_m.exists(a) != 0) return csr_m[a];
        else return 32'd0;
    endfunction

    task automatic model_reset();
        csr_m.delete();
        csr_m[12'h300] = 32'd0; csr_m[12'h304] = 32'd0; csr_m[12'h305] = 32'h0000_0100;
        csr_m[12'h340] = 32'd0; csr_m[12'h341] = 32'd0; csr_m[12'h342] = 32'd0;
        csr_m[12'h343] = 32'd0;
        mcyc = 64'd0;
        m_redirect = 1'b0;
    endtask

    task automatic take_trap(input logic [31:0] cause, input logic [31:0] tval);
        exp_t e;
        logic [31:0] ms;
        e.cyc = cyc + 1; e.data = csr_m[12'h305];
        rdr_q.push_back(e);
        ms = csr_m[12'h300];
        csr_m[12'h341] = pc_i & 32'hFFFF_FFFC;
        csr_m[12'h342] = cause;
        csr_m[12'h343] = tval;
        csr_m[12'h300] = ms[3] ? 32'h0000_0080 : 32'd0;
        m_redirect = 1'b1;
    endtask

    // Evaluate the current cycle's inputs: queue expectations, advance model one clock.
    task automatic model_eval();
        exp_t e;
        logic [31:0] old, nv, ms, me;
        bit any, skip;
        skip = 1'b0;
        old = model_read(csr_addr_i);
        e.cyc = cyc; e.data = old;
        rd_q.push_back(e);
        any = csr_write_i | csr_set_i | csr_clear_i;
        ms = csr_m[12'h300];
        me = csr_m[12'h304];
        if (m_redirect) begin
            m_redirect = 1'b0;
        end else if (valid_i) begin
            if (ms[3] && me[11] && irq_ext_i) take_trap(32'h8000_000B, 32'd0);
            else if (ms[3] && me[7] && irq_timer_i) take_trap(32'h8000_0007, 32'd0);
            else if (illegal_i || (any && !known(csr_addr_i))) take_trap(32'd2, instr_i);
            else if (mret_i) begin
                e.cyc = cyc + 1; e.data = csr_m[12'h341];
                rdr_q.push_back(e);
                csr_m[12'h300] = 32'h0000_0080 | (ms[7] ? 32'h0000_0008 : 32'd0);
                m_redirect = 1'b1;
            end else if (any) begin
                nv = csr_write_i ? csr_wdata_i : (csr_set_i ? (old | csr_wdata_i) : (old & ~csr_wdata_i));
                if (csr_addr_i == 12'hB00 || csr_addr_i == 12'hB80) begin
                    if (csr_write_i || csr_wdata_i != 32'd0) begin
                        skip = 1'b1;
                        if (csr_addr_i == 12'hB00) mcyc[31:0] = nv;
                        else mcyc[63:32] = nv;
                    end
                end else if (csr_addr_i != 12'h344) begin
                    csr_m[csr_addr_i] = nv & wmask(csr_addr_i);
                end
            end
        end
        if (!skip) mcyc = mcyc + 64'd1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                         input logic il, input logic mr);
        next_cycle();
        valid_i = v; pc_i = pc; instr_i = ins;
        csr_write_i = (op == WR); csr_set_i = (op == ST); csr_clear_i = (op == CL);
        csr_addr_i = a; csr_wdata_i = wd; illegal_i = il; mret_i = mr;
        irq_ext_i = ext_nxt; irq_timer_i = tmr_nxt;
        model_eval();
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
        issue(1'b1, 32'h0000_1000, 32'h0000_0073, op, a, wd, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [11:0] a);
        issue(1'b0, 32'd0, 32'd0, NO, a, 32'd0, 1'b0, 1'b0);
    endtask

    // Caller drops rst_n; hold it, then release in a cycle the model also evaluates.
    task automatic reset_hold();
        valid_i = 1'b0; csr_write_i = 1'b0; csr_set_i = 1'b0; csr_clear_i = 1'b0;
        illegal_i = 1'b0; mret_i = 1'b0; irq_ext_i = 1'b0; irq_timer_i = 1'b0;
        ext_nxt = 1'b0; tmr_nxt = 1'b0; csr_addr_i = 12'h305;
        rd_q.delete(); rdr_q.delete();
        repeat (2) next_cycle();
        rst_n = 1'b1;
        model_reset();
        model_eval();
        check("redirect_after_reset", {63'd0, redirect_o}, 64'd0);
    endtask

    // Monitor: compare read data every cycle and each redirect against the queues.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
                e = rd_q.pop_front();
                check("csr_rdata", {32'd0, csr_rdata_o}, {32'd0, e.data});
            end
            if (redirect_o) begin
                if (rdr_q.size() == 0) begin
                    check("unexpected_redirect", {63'd0, redirect_o}, 64'd0);
                end else begin
                    e = rdr_q.pop_front();
                    check("redirect_pc", {32'd0, redirect_pc_o}, {32'd0, e.data});
                    check("redirect_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else if (rdr_q.size() > 0 && rdr_q[0].cyc <= cyc) begin
                e = rdr_q.pop_front();
                check("missing_redirect", {63'd0, redirect_o}, 64'd1);
            end
        end
    end

    initial begin
        reset_hold();
        foreach (addr_tbl[i]) rd(addr_tbl[i]);

        // mscratch write/set, MIE on
        csr(WR, 12'h300, 32'h0000_0008);
        csr(WR, 12'h340, 32'hDEAD_BEEF);
        csr(ST, 12'h340, 32'h0000_0001);
        rd(12'h340);

        // illegal instruction trap; redirect cycle ignores its CSR write
        issue(1'b1, 32'h0000_0040, 32'hFFFF_FFFF, NO, 12'h340, 32'd0, 1'b1, 1'b0);
        csr(WR, 12'h340, 32'h1111_1111);
        rd(12'h341); rd(12'h342); rd(12'h343); rd(12'h300); rd(12'h340);

        // timer interrupt suppresses a same-cycle mscratch write
        csr(WR, 12'h304, 32'h0000_0080);
        csr(ST, 12'h300, 32'h0000_0008);
        tmr_nxt = 1'b1;
        issue(1'b1, 32'h0000_0200, 32'h3400_1073, WR, 12'h340, 32'h1234_5678, 1'b0, 1'b0);
        tmr_nxt = 1'b0;
        rd(12'h341); rd(12'h340); rd(12'h342); rd(12'h343);

        // MRET to mepc 0x44 (low bits forced to zero)
        csr(WR, 12'h341, 32'h0000_0047);
        issue(1'b1, 32'h0000_0300, 32'h3020_0073, NO, 12'h300, 32'd0, 1'b0, 1'b1);
        rd(12'h300); rd(12'h300); rd(12'h341);

        // external beats timer beats illegal; back-to-back illegal right after redirect
        csr(ST, 12'h304, 32'h0000_0800);
        ext_nxt = 1'b1; tmr_nxt = 1'b1;
        issue(1'b1, 32'h0000_0500, 32'h0000_0000, NO, 12'h344, 32'd0, 1'b1, 1'b0);
        ext_nxt = 1'b0; tmr_nxt = 1'b0;
        rd(12'h342);
        issue(1'b1, 32'h0000_0600, 32'hABCD_0001, NO, 12'h342, 32'd0, 1'b1, 1'b0);
        rd(12'h342); rd(12'h343); rd(12'h341); rd(12'h300);

        // masking, read-only mip, zero-operand set/clear, clear
        csr(WR, 12'h305, 32'h0000_0203); rd(12'h305);
        csr(WR, 12'h344, 32'hFFFF_FFFF); rd(12'h344);
        csr(ST, 12'h340, 32'd0); csr(CL, 12'h340, 32'd0);
        csr(CL, 12'h340, 32'hFFFF_0000); rd(12'h340);

        // mcycle carry into mcycleh, then full 64-bit wrap
        csr(WR, 12'hB80, 32'd0); csr(WR, 12'hB00, 32'hFFFF_FFFF);
        rd(12'hB00); rd(12'hB00); rd(12'hB80);
        csr(WR, 12'hB80, 32'hFFFF_FFFF); csr(WR, 12'hB00, 32'hFFFF_FFFF);
        rd(12'hB00); rd(12'hB80); rd(12'hB80);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            ext_nxt = ($urandom_range(0, 9) == 0);
            tmr_nxt = ($urandom_range(0, 9) == 0);
            issue($urandom_range(0, 3) != 0, $urandom(), $urandom(),
                  2'($urandom_range(0, 3)), addr_tbl[$urandom_range(0, 11)],
                  (r < 20) ? 32'd0 : $urandom(), r >= 95, (r >= 90) && (r < 95));
        end
        ext_nxt = 1'b0; tmr_nxt = 1'b0;
        rd(12'h300); rd(12'h342);

        // unknown CSR traps; reset during the redirect drops it at once
        csr(ST, 12'h7C0, 32'h0000_0001);
        next_cycle();
        valid_i = 1'b0; csr_set_i = 1'b0; csr_addr_i = 12'h342;
        #1;
        check("mcause_unknown_csr", {32'd0, csr_rdata_o}, 64'd2);
        check("redirect_before_reset", {63'd0, redirect_o}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("redirect_drop_on_reset", {63'd0, redirect_o}, 64'd0);
        reset_hold();
        rd(12'h300); rd(12'h341); rd(12'hB00);
        rd(12'h300);
        check("pending_redirects", 64'(rdr_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
